// File: rtl/gear_shifter_multi_if.sv
// rtl/gear_shifter_multi_if.sv - player button, direct-select and gear/switch-line bundle
interface gear_shifter_multi_if #(
  parameter int PLAYERS = 2,
  parameter int GEARS   = 4,
  parameter int GW      = (GEARS > 2) ? $clog2(GEARS) : 1
);
  logic [PLAYERS-1:0]           gearup;
  logic [PLAYERS-1:0]           geardown;
  logic [PLAYERS-1:0]           gear_sel_en;
  logic [PLAYERS*GW-1:0]        gear_sel;
  logic [PLAYERS*GW-1:0]        gear;
  logic [PLAYERS*(GEARS-1)-1:0] gear_sw_n;
  logic [PLAYERS-1:0]           shifted;

  modport master (
    output gearup, geardown, gear_sel_en, gear_sel,
    input  gear, gear_sw_n, shifted
  );

  modport slave (
    input  gearup, geardown, gear_sel_en, gear_sel,
    output gear, gear_sw_n, shifted
  );
endinterface

// File: rtl/gear_shifter_multi.sv
// rtl/gear_shifter_multi.sv - per-player synchronised, debounced, saturating gear register
// with direct-select load and active-low gear switch decode.
module gear_shifter_multi #(
  parameter int PLAYERS  = 2,
  parameter int GEARS    = 4,
  parameter int DEBOUNCE = 4
) (
  input logic                 CLK,
  input logic                 reset_n,
  gear_shifter_multi_if.slave bus
);
  localparam int GW = (GEARS > 2) ? $clog2(GEARS) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [GW-1:0] TOP = GW'(GEARS - 1);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    // Bit 0 carries gear-up, bit 1 carries gear-down throughout the button path.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [CW-1:0] cnt [2];
    logic          up_ev;
    logic          dn_ev;
    logic [GW-1:0] sel;
    logic [GW-1:0] sel_clamped;
    logic [GW-1:0] gear_r;
    logic [GW-1:0] gear_q;
    logic          shifted_r;

    assign raw = {bus.geardown[p], bus.gearup[p]};

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        s1     <= '0;
        s2     <= '0;
        db     <= '0;
        db_q   <= '0;
        cnt[0] <= '0;
        cnt[1] <= '0;
      end else begin
        s1   <= raw;
        s2   <= s1;
        db_q <= db;
        for (int b = 0; b < 2; b++) begin
          if (s2[b] == db[b]) begin
            cnt[b] <= '0;
          end else if (cnt[b] == CW'(DEBOUNCE - 1)) begin
            db[b]  <= s2[b];
            cnt[b] <= '0;
          end else begin
            cnt[b] <= cnt[b] + CW'(1);
          end
        end
      end
    end

    // Only a debounced rising level is a press; releases and held buttons do nothing.
    assign up_ev       = db[0] & ~db_q[0];
    assign dn_ev       = db[1] & ~db_q[1];
    assign sel         = bus.gear_sel[p*GW +: GW];
    assign sel_clamped = (sel > TOP) ? TOP : sel;

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        gear_r    <= '0;
        gear_q    <= '0;
        shifted_r <= 1'b0;
      end else begin
        gear_q    <= gear_r;
        shifted_r <= (gear_r != gear_q);
        if (bus.gear_sel_en[p]) begin
          gear_r <= sel_clamped;
        end else if (up_ev && !dn_ev && gear_r != TOP) begin
          gear_r <= gear_r + GW'(1);
        end else if (dn_ev && !up_ev && gear_r != '0) begin
          gear_r <= gear_r - GW'(1);
        end
      end
    end

    assign bus.gear[p*GW +: GW] = gear_r;
    assign bus.shifted[p]       = shifted_r;

    // Top gear has no line of its own: every line reads high there.
    for (genvar g = 0; g < GEARS - 1; g++) begin : g_sw
      assign bus.gear_sw_n[p*(GEARS-1) + g] = (gear_r != GW'(g));
    end
  end
endmodule

// File: tb/tb_gear_shifter_multi.sv
// tb/tb_gear_shifter_multi.sv - table vectors plus shift-pulse scoreboard for gear_shifter_multi
module tb_gear_shifter_multi;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  gear_shifter_multi_if #(.PLAYERS(2), .GEARS(4)) bus ();
  gear_shifter_multi_if #(.PLAYERS(1), .GEARS(3)) bus3 ();

  gear_shifter_multi #(.PLAYERS(2), .GEARS(4), .DEBOUNCE(4)) dut (
    .CLK(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  gear_shifter_multi #(.PLAYERS(1), .GEARS(3), .DEBOUNCE(2)) dut3 (
    .CLK(clk), .reset_n(reset_n), .bus(bus3.slave)
  );

  typedef struct {
    logic [1:0] up;
    logic [1:0] dn;
    int         g0;
    int         g1;
    logic [2:0] sw0;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;
  int   ntick  = 0;
  int   q0[$];
  int   q1[$];
  int   last_pulse[2];
  int   t0, td, prev0, prev1, e;

  function automatic int gear_of(input int p);
    return int'(bus.gear[p*2 +: 2]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every shifted pulse must match the oldest expected gear step for that player.
  task automatic tick();
    @(posedge clk);
    #1;
    ntick++;
    for (int p = 0; p < 2; p++) begin
      if (bus.shifted[p]) begin
        last_pulse[p] = ntick;
        if ((p == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_shift_p%0d: got gear %0d with no step expected", p, gear_of(p));
        end else begin
          e = (p == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("sb_gear_p%0d", p), gear_of(p), e);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int p, input int hold);
    bus.gearup[p] = 1'b1;
    ticks(hold);
    bus.gearup[p] = 1'b0;
    ticks(10);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 2'b00, 1, 0, 3'b101};
    vecs[1]  = '{2'b01, 2'b00, 2, 0, 3'b011};
    vecs[2]  = '{2'b01, 2'b00, 3, 0, 3'b111};
    vecs[3]  = '{2'b01, 2'b00, 3, 0, 3'b111};
    vecs[4]  = '{2'b01, 2'b00, 3, 0, 3'b111};
    vecs[5]  = '{2'b00, 2'b01, 2, 0, 3'b011};
    vecs[6]  = '{2'b00, 2'b01, 1, 0, 3'b101};
    vecs[7]  = '{2'b00, 2'b01, 0, 0, 3'b110};
    vecs[8]  = '{2'b00, 2'b01, 0, 0, 3'b110};
    vecs[9]  = '{2'b00, 2'b01, 0, 0, 3'b110};
    vecs[10] = '{2'b11, 2'b00, 1, 1, 3'b101};
    vecs[11] = '{2'b01, 2'b01, 1, 1, 3'b101};
    vecs[12] = '{2'b00, 2'b10, 1, 0, 3'b101};

    last_pulse[0]    = -1;
    last_pulse[1]    = -1;
    bus.gear_sel_en  = '0;
    bus.gear_sel     = '0;
    bus3.gearup      = '0;
    bus3.geardown    = '0;
    bus3.gear_sel_en = '0;
    bus3.gear_sel    = '0;

    reset_n      = 1'b0;
    bus.gearup   = 2'b11;
    bus.geardown = 2'b11;
    ticks(4);
    chk("reset_gear", int'(bus.gear), 0);
    chk("reset_sw_n", int'(bus.gear_sw_n), 6'b110110);
    chk("reset_shifted", int'(bus.shifted), 0);
    chk("reset_gear3", int'(bus3.gear), 0);
    chk("reset_sw_n3", int'(bus3.gear_sw_n), 2'b10);
    bus.gearup   = '0;
    bus.geardown = '0;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    chk("post_reset_gear", int'(bus.gear), 0);

    t0 = ntick;
    q0.push_back(1);
    bus.gearup[0] = 1'b1;
    ticks(6);
    chk("lat_before", gear_of(0), 0);
    tick();
    chk("lat_at_edge6", gear_of(0), 1);
    chk("lat_sw_n", int'(bus.gear_sw_n[2:0]), 3'b101);
    ticks(13);
    chk("hold_gear", gear_of(0), 1);
    chk("lat_pulse_tick", last_pulse[0], t0 + 8);
    bus.gearup[0] = 1'b0;
    ticks(10);

    press(0, 3);
    chk("debounce_3cyc", gear_of(0), 1);
    q0.push_back(2);
    press(0, 4);
    chk("debounce_4cyc", gear_of(0), 2);
    chk("sb_empty_p0_a", q0.size(), 0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ticks(3);

    prev0 = 0;
    prev1 = 0;
    foreach (vecs[i]) begin
      if (vecs[i].g0 != prev0) q0.push_back(vecs[i].g0);
      if (vecs[i].g1 != prev1) q1.push_back(vecs[i].g1);
      bus.gearup   = vecs[i].up;
      bus.geardown = vecs[i].dn;
      ticks(6);
      bus.gearup   = '0;
      bus.geardown = '0;
      ticks(10);
      chk($sformatf("vec%0d_g0", i), gear_of(0), vecs[i].g0);
      chk($sformatf("vec%0d_g1", i), gear_of(1), vecs[i].g1);
      chk($sformatf("vec%0d_sw0", i), int'(bus.gear_sw_n[2:0]), int'(vecs[i].sw0));
      chk($sformatf("vec%0d_sb_empty", i), q0.size() + q1.size(), 0);
      prev0 = vecs[i].g0;
      prev1 = vecs[i].g1;
    end

    q0.push_back(2);
    press(0, 6);
    chk("pre_areset_gear", gear_of(0), 2);
    bus.gearup[0] = 1'b1;
    ticks(3);
    #3 reset_n = 1'b0;
    #1;
    chk("areset_gear", int'(bus.gear), 0);
    chk("areset_sw_n", int'(bus.gear_sw_n), 6'b110110);
    chk("areset_shifted", int'(bus.shifted), 0);
    ticks(2);
    bus.gearup[0] = 1'b0;
    reset_n = 1'b1;
    ticks(12);
    chk("post_areset_gear", gear_of(0), 0);

    td = ntick;
    q1.push_back(2);
    bus.gear_sel    = 4'b1000;
    bus.gear_sel_en = 2'b10;
    tick();
    chk("direct_load", gear_of(1), 2);
    ticks(5);
    chk("direct_pulse_tick", last_pulse[1], td + 2);
    chk("direct_p0_idle", gear_of(0), 0);
    press(1, 6);
    chk("direct_ignores_btn", gear_of(1), 2);
    bus.gear_sel_en = 2'b00;
    ticks(4);
    chk("mode_switch_hold", gear_of(1), 2);
    q1.push_back(3);
    press(1, 6);
    chk("after_switch_press", gear_of(1), 3);

    bus3.gear_sel    = 2'd3;
    bus3.gear_sel_en = 1'b1;
    tick();
    chk("g3_clamp_gear", int'(bus3.gear), 2);
    chk("g3_clamp_sw_n", int'(bus3.gear_sw_n), 2'b11);
    bus3.gear_sel = 2'd1;
    tick();
    chk("g3_sel1_gear", int'(bus3.gear), 1);
    chk("g3_sel1_sw_n", int'(bus3.gear_sw_n), 2'b01);

    ticks(4);
    chk("sb_final_p0", q0.size(), 0);
    chk("sb_final_p1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
